// File: rtl/mips_debug_unit.sv
`timescale 1ns/1ps
`default_nettype none
// mips_debug_unit -- UART byte-stream endpoint that loads, runs and single-steps the mips core.
// Rev 1.0
module mips_debug_unit #(
   parameter int          IMEM_ADDR_W  = 8,
   parameter logic [31:0] RUN_TIMEOUT  = 32'h000F_FFFF,
   parameter int          DRAIN_CYCLES = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [7:0]             i_rx_data,
   input  logic                   i_rx_valid,
   output logic [7:0]             o_tx_data,
   output logic                   o_tx_valid,
   input  logic                   i_tx_ready,
   output logic                   o_imem_we,
   output logic [IMEM_ADDR_W-1:0] o_imem_addr,
   output logic [31:0]            o_imem_wdata,
   output logic                   o_cpu_reset,
   output logic                   o_cpu_en,
   input  logic [31:0]            i_result,
   input  logic                   i_halt
);
   typedef enum logic [2:0] {
      IDLE, LOAD_LEN, LOAD_DATA, LOAD_WR, RUN, DRAIN, STEP, SEND
   } state_t;

   state_t                 state_q, state_d;
   logic [71:0]            tx_sr_q, tx_sr_d;
   logic [3:0]             tx_left_q, tx_left_d;
   logic [31:0]            word_q, word_d;
   logic [1:0]             byte_idx_q, byte_idx_d;
   logic [7:0]             words_left_q, words_left_d;
   logic [IMEM_ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]            cycles_q, cycles_d;
   logic [31:0]            last_result_q, last_result_d;
   logic [7:0]             drain_left_q, drain_left_d;
   logic                   halted_q, halted_d;
   logic                   cpu_reset_q, cpu_reset_d;

   always_comb begin
      state_d       = state_q;
      tx_sr_d       = tx_sr_q;
      tx_left_d     = tx_left_q;
      word_d        = word_q;
      byte_idx_d    = byte_idx_q;
      words_left_d  = words_left_q;
      addr_d        = addr_q;
      cycles_d      = cycles_q;
      last_result_d = last_result_q;
      drain_left_d  = drain_left_q;
      halted_d      = halted_q;
      cpu_reset_d   = cpu_reset_q;

      // Counter and result capture run ahead of the FSM so the report can use this cycle's values.
      if (state_q == RUN || state_q == DRAIN) begin
         cycles_d = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;
         if (i_result != 32'd0) last_result_d = i_result;
      end

      case (state_q)
         IDLE: begin
            if (i_rx_valid) begin
               case (i_rx_data)
                  8'h4C: begin
                     cpu_reset_d = 1'b1;
                     state_d     = LOAD_LEN;
                  end
                  8'h52: begin
                     cpu_reset_d = 1'b0;
                     cycles_d    = 32'd0;
                     state_d     = RUN;
                  end
                  8'h53: begin
                     cpu_reset_d = 1'b0;
                     state_d     = STEP;
                  end
                  default: begin
                     tx_sr_d   = {64'd0, 8'h15};
                     tx_left_d = 4'd1;
                     state_d   = SEND;
                  end
               endcase
            end
         end
         LOAD_LEN: begin
            if (i_rx_valid) begin
               // Stored as N-1 so that a length byte of 0 wraps to 256 words.
               words_left_d = i_rx_data - 8'd1;
               addr_d       = '0;
               byte_idx_d   = 2'd0;
               state_d      = LOAD_DATA;
            end
         end
         LOAD_DATA: begin
            if (i_rx_valid) begin
               word_d     = {i_rx_data, word_q[31:8]};
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) state_d = LOAD_WR;
            end
         end
         LOAD_WR: begin
            addr_d = addr_q + 1'b1;
            if (words_left_q == 8'd0) begin
               tx_sr_d   = {64'd0, 8'h06};
               tx_left_d = 4'd1;
               state_d   = SEND;
            end else begin
               words_left_d = words_left_q - 8'd1;
               state_d      = LOAD_DATA;
               // A byte may arrive back-to-back with the write cycle; it starts the next word.
               if (i_rx_valid) begin
                  word_d     = {i_rx_data, word_q[31:8]};
                  byte_idx_d = byte_idx_q + 2'd1;
               end
            end
         end
         RUN: begin
            if (i_halt) begin
               halted_d     = 1'b1;
               drain_left_d = 8'(DRAIN_CYCLES - 1);
               state_d      = DRAIN;
            end else if (cycles_d >= RUN_TIMEOUT) begin
               halted_d     = 1'b0;
               drain_left_d = 8'(DRAIN_CYCLES - 1);
               state_d      = DRAIN;
            end
         end
         DRAIN: begin
            if (drain_left_q == 8'd0) begin
               tx_sr_d   = {last_result_d, cycles_d, (halted_q ? 8'h48 : 8'h54)};
               tx_left_d = 4'd9;
               state_d   = SEND;
            end else begin
               drain_left_d = drain_left_q - 8'd1;
            end
         end
         STEP: begin
            tx_sr_d   = {40'd0, i_result};
            tx_left_d = 4'd4;
            state_d   = SEND;
         end
         SEND: begin
            if (i_tx_ready) begin
               tx_sr_d   = {8'd0, tx_sr_q[71:8]};
               tx_left_d = tx_left_q - 4'd1;
               if (tx_left_q == 4'd1) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         tx_sr_q       <= '0;
         tx_left_q     <= '0;
         word_q        <= '0;
         byte_idx_q    <= '0;
         words_left_q  <= '0;
         addr_q        <= '0;
         cycles_q      <= '0;
         last_result_q <= '0;
         drain_left_q  <= '0;
         halted_q      <= 1'b0;
         cpu_reset_q   <= 1'b1;
      end else begin
         state_q       <= state_d;
         tx_sr_q       <= tx_sr_d;
         tx_left_q     <= tx_left_d;
         word_q        <= word_d;
         byte_idx_q    <= byte_idx_d;
         words_left_q  <= words_left_d;
         addr_q        <= addr_d;
         cycles_q      <= cycles_d;
         last_result_q <= last_result_d;
         drain_left_q  <= drain_left_d;
         halted_q      <= halted_d;
         cpu_reset_q   <= cpu_reset_d;
      end
   end

   assign o_tx_data    = tx_sr_q[7:0];
   assign o_tx_valid   = (state_q == SEND);
   assign o_imem_we    = (state_q == LOAD_WR);
   assign o_imem_addr  = addr_q;
   assign o_imem_wdata = word_q;
   assign o_cpu_reset  = cpu_reset_q;
   assign o_cpu_en     = (state_q == RUN) || (state_q == DRAIN) || (state_q == STEP);
endmodule
`default_nettype wire

// File: tb/tb_mips_debug_unit.sv
`timescale 1ns/1ps
`default_nettype none
// tb_mips_debug_unit -- scoreboard bench for mips_debug_unit (load, run, timeout, step, reset).
// Rev 1.0
module tb_mips_debug_unit;
   logic        clk;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_reset;
   logic        cpu_en;
   logic [31:0] result;
   logic        halt;

   int n_checks;
   int n_errors;
   int ph;
   bit bp_mode;
   bit prev_stall;
   logic [7:0]  prev_data;
   logic [7:0]  tx_q[$];
   logic [31:0] ea_q[$];
   logic [31:0] ed_q[$];

   mips_debug_unit #(
      .IMEM_ADDR_W (8),
      .RUN_TIMEOUT (32'd100),
      .DRAIN_CYCLES(4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .i_rx_data   (rx_data),
      .i_rx_valid  (rx_valid),
      .o_tx_data   (tx_data),
      .o_tx_valid  (tx_valid),
      .i_tx_ready  (tx_ready),
      .o_imem_we   (imem_we),
      .o_imem_addr (imem_addr),
      .o_imem_wdata(imem_wdata),
      .o_cpu_reset (cpu_reset),
      .o_cpu_en    (cpu_en),
      .i_result    (result),
      .i_halt      (halt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic put(input logic [7:0] b);
      @(posedge clk); #1;
      rx_data  = b;
      rx_valid = 1'b1;
   endtask

   task automatic idle_rx();
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      put(b);
      idle_rx();
   endtask

   task automatic push4(input logic [31:0] v);
      tx_q.push_back(v[7:0]);
      tx_q.push_back(v[15:8]);
      tx_q.push_back(v[23:16]);
      tx_q.push_back(v[31:24]);
   endtask

   task automatic wait_tx_done(input string tag);
      int n = 0;
      while ((tx_q.size() != 0 || tx_valid) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check(tag, tx_q.size(), 0);
   endtask

   // Transmitter model: always ready, or toggling every 3 cycles when backpressure is on.
   initial begin
      ph       = 0;
      tx_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (bp_mode) begin
            ph++;
            if (ph == 3) begin
               ph       = 0;
               tx_ready = !tx_ready;
            end
         end else begin
            tx_ready = 1'b1;
         end
      end
   end

   // Scoreboard consumer: tx handshakes and imem writes are popped against expectations.
   initial begin
      prev_stall = 1'b0;
      prev_data  = 8'd0;
      forever begin
         logic [7:0]  eb;
         logic [31:0] ea, ed;
         @(negedge clk);
         if (!reset) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall)
               check("tx_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, prev_data});
            if (tx_valid && tx_ready) begin
               if (tx_q.size() == 0) check("tx_unexpected", tx_q.size(), 1);
               else begin
                  eb = tx_q.pop_front();
                  check("tx_byte", {24'd0, tx_data}, {24'd0, eb});
               end
            end
            if (imem_we) begin
               if (ea_q.size() == 0) check("imem_unexpected", ea_q.size(), 1);
               else begin
                  ea = ea_q.pop_front();
                  ed = ed_q.pop_front();
                  check("imem_addr", {24'd0, imem_addr}, ea);
                  check("imem_wdata", imem_wdata, ed);
               end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
         end
      end
   end

   initial begin
      int n, n_en;
      bit first;
      logic [31:0] v;
      n_checks = 0;
      n_errors = 0;
      bp_mode  = 1'b0;
      reset    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'd0;
      result   = 32'd0;
      halt     = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ctrl", {28'd0, cpu_reset, cpu_en, imem_we, tx_valid}, 32'b1000);
      check("rst_addr", {24'd0, imem_addr}, 32'd0);
      check("rst_wdata", imem_wdata, 32'd0);
      check("rst_txdata", {24'd0, tx_data}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;

      // Load two words, bytes back-to-back.
      ea_q.push_back(32'd0); ed_q.push_back(32'h1234_5678);
      ea_q.push_back(32'd1); ed_q.push_back(32'hDEAD_BEEF);
      tx_q.push_back(8'h06);
      put(8'h4C); put(8'h02);
      put(8'h78); put(8'h56); put(8'h34); put(8'h12);
      put(8'hEF); put(8'hBE); put(8'hAD); put(8'hDE);
      idle_rx();
      check("load_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      wait_tx_done("load_tx");
      check("load_imem_left", ea_q.size(), 0);

      // Run to halt, with backpressure on the report.
      tx_q.push_back(8'h48); push4(32'd14); push4(32'h2A);
      bp_mode = 1'b1;
      send_byte(8'h52);
      n = 0; n_en = 0; first = 1'b1;
      while (!tx_valid && n < 300) begin
         @(negedge clk);
         n++;
         if (first) begin
            check("run_en_t1", {31'd0, cpu_en}, 32'd1);
            first = 1'b0;
         end
         if (cpu_en) begin
            n_en++;
            if (n_en == 10) begin
               halt   = 1'b1;
               result = 32'h2A;
            end
         end
      end
      check("run_en_off", {31'd0, cpu_en}, 32'd0);
      check("run_en_cycles", n_en, 14);
      check("run_cpu_reset", {31'd0, cpu_reset}, 32'd0);
      halt = 1'b0;
      wait_tx_done("run_tx");
      bp_mode = 1'b0;

      // Timeout run with rx noise that must be ignored.
      result = 32'h77;
      tx_q.push_back(8'h54); push4(32'd104); push4(32'h77);
      send_byte(8'h52);
      n = 0; n_en = 0;
      while (!tx_valid && n < 400) begin
         @(negedge clk);
         n++;
         if (cpu_en) n_en++;
         if (n_en == 5 || n_en == 50) begin
            rx_data  = (n_en == 5) ? 8'h58 : 8'h4C;
            rx_valid = 1'b1;
         end else begin
            rx_valid = 1'b0;
         end
      end
      rx_valid = 1'b0;
      check("timeout_en_cycles", n_en, 104);
      wait_tx_done("timeout_tx");

      // Two single steps.
      for (int k = 0; k < 2; k++) begin
         v      = (k == 0) ? 32'h11 : 32'h22;
         result = v;
         push4(v);
         send_byte(8'h53);
         n = 0; n_en = 0;
         while (!tx_valid && n < 50) begin
            @(negedge clk);
            n++;
            if (cpu_en) n_en++;
         end
         check("step_en_cycles", n_en, 1);
         check("step_cpu_reset", {31'd0, cpu_reset}, 32'd0);
         wait_tx_done("step_tx");
      end

      // Reset in the middle of a load: word 0 is written, the fifth byte is abandoned.
      ea_q.push_back(32'd0); ed_q.push_back(32'h0403_0201);
      put(8'h4C); put(8'h02);
      put(8'h01); put(8'h02); put(8'h03); put(8'h04); put(8'h05);
      @(posedge clk); #2;
      reset    = 1'b0;
      rx_valid = 1'b0;
      #1;
      check("mid_rst_ctrl", {28'd0, cpu_reset, cpu_en, imem_we, tx_valid}, 32'b1000);
      check("mid_rst_addr", {24'd0, imem_addr}, 32'd0);
      check("mid_rst_wdata", imem_wdata, 32'd0);
      check("mid_rst_txdata", {24'd0, tx_data}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      tx_q.push_back(8'h15);
      send_byte(8'h58);
      @(negedge clk);
      check("nak_latency", {31'd0, tx_valid}, 32'd1);
      wait_tx_done("nak_tx");
      check("final_imem_left", ea_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
